// File: rtl/axi4lite_rr_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite slave port between NUM_M
// masters. The read and write paths each have their own grant, their own
// round-robin pointer and one outstanding transaction. Channels of the
// granted master are forwarded combinationally with no buffering.
module axi4lite_rr_arbiter #(
    parameter int NUM_M = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    // master-side write address / data / response
    input  logic [NUM_M-1:0]        m_aw_valid,
    output logic [NUM_M-1:0]        m_aw_ready,
    input  logic [NUM_M*AW-1:0]     m_aw_addr,
    input  logic [NUM_M-1:0]        m_w_valid,
    output logic [NUM_M-1:0]        m_w_ready,
    input  logic [NUM_M*DW-1:0]     m_w_data,
    input  logic [NUM_M*(DW/8)-1:0] m_w_strb,
    output logic [NUM_M-1:0]        m_b_valid,
    input  logic [NUM_M-1:0]        m_b_ready,
    output logic [1:0]              m_b_resp,

    // master-side read address / data
    input  logic [NUM_M-1:0]        m_ar_valid,
    output logic [NUM_M-1:0]        m_ar_ready,
    input  logic [NUM_M*AW-1:0]     m_ar_addr,
    output logic [NUM_M-1:0]        m_r_valid,
    input  logic [NUM_M-1:0]        m_r_ready,
    output logic [DW-1:0]           m_r_data,
    output logic [1:0]              m_r_resp,

    // slave-side port
    output logic                    s_aw_valid,
    input  logic                    s_aw_ready,
    output logic [AW-1:0]           s_aw_addr,
    output logic                    s_w_valid,
    input  logic                    s_w_ready,
    output logic [DW-1:0]           s_w_data,
    output logic [DW/8-1:0]         s_w_strb,
    input  logic                    s_b_valid,
    output logic                    s_b_ready,
    input  logic [1:0]              s_b_resp,
    output logic                    s_ar_valid,
    input  logic                    s_ar_ready,
    output logic [AW-1:0]           s_ar_addr,
    input  logic                    s_r_valid,
    output logic                    s_r_ready,
    input  logic [DW-1:0]           s_r_data,
    input  logic [1:0]              s_r_resp
);

    localparam int              IW     = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int              SW     = DW / 8;
    localparam logic [IW-1:0]   LAST_M = IW'(NUM_M - 1);

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

    // First requester found searching upward from ptr, wrapping at NUM_M.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_M-1:0] req,
                                              input logic [IW-1:0]    ptr);
        logic [IW-1:0] pick;
        logic [IW-1:0] idx;
        logic          found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            idx = IW'((int'(ptr) + k) % NUM_M);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // The master after the one just served gets top priority next time.
    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
        return (g == LAST_M) ? '0 : g + 1'b1;
    endfunction

    wstate_e       wstate_q, wstate_d;
    logic [IW-1:0] wgrant_q, wgrant_d;
    logic [IW-1:0] wptr_q,   wptr_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q,  w_done_d;

    rstate_e       rstate_q, rstate_d;
    logic [IW-1:0] rgrant_q, rgrant_d;
    logic [IW-1:0] rptr_q,   rptr_d;

    logic [AW-1:0] aw_addr_arr [NUM_M];
    logic [AW-1:0] ar_addr_arr [NUM_M];
    logic [DW-1:0] w_data_arr  [NUM_M];
    logic [SW-1:0] w_strb_arr  [NUM_M];

    logic [NUM_M-1:0] wgrant_oh;
    logic [NUM_M-1:0] rgrant_oh;

    // Channel phases during which the granted master is connected through.
    logic aw_fwd, w_fwd, b_fwd, ar_fwd, r_fwd;
    assign aw_fwd = (wstate_q == W_XFER) && !aw_done_q;
    assign w_fwd  = (wstate_q == W_XFER) && !w_done_q;
    assign b_fwd  = (wstate_q == W_RESP);
    assign ar_fwd = (rstate_q == R_ADDR);
    assign r_fwd  = (rstate_q == R_DATA);

    // Unpack flat per-master buses and route per-master handshake outputs.
    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_master
        assign aw_addr_arr[gi] = m_aw_addr[gi*AW +: AW];
        assign ar_addr_arr[gi] = m_ar_addr[gi*AW +: AW];
        assign w_data_arr[gi]  = m_w_data[gi*DW +: DW];
        assign w_strb_arr[gi]  = m_w_strb[gi*SW +: SW];

        assign m_aw_ready[gi]  = aw_fwd && wgrant_oh[gi] && s_aw_ready;
        assign m_w_ready[gi]   = w_fwd  && wgrant_oh[gi] && s_w_ready;
        assign m_b_valid[gi]   = b_fwd  && wgrant_oh[gi] && s_b_valid;
        assign m_ar_ready[gi]  = ar_fwd && rgrant_oh[gi] && s_ar_ready;
        assign m_r_valid[gi]   = r_fwd  && rgrant_oh[gi] && s_r_valid;
    end

    // One-hot decode of both grants.
    always_comb begin
        wgrant_oh           = '0;
        wgrant_oh[wgrant_q] = 1'b1;
        rgrant_oh           = '0;
        rgrant_oh[rgrant_q] = 1'b1;
    end

    // Slave-side forwarding from the granted master; data always muxed.
    assign s_aw_valid = aw_fwd && m_aw_valid[wgrant_q];
    assign s_aw_addr  = aw_addr_arr[wgrant_q];
    assign s_w_valid  = w_fwd && m_w_valid[wgrant_q];
    assign s_w_data   = w_data_arr[wgrant_q];
    assign s_w_strb   = w_strb_arr[wgrant_q];
    assign s_b_ready  = b_fwd && m_b_ready[wgrant_q];
    assign m_b_resp   = s_b_resp;

    assign s_ar_valid = ar_fwd && m_ar_valid[rgrant_q];
    assign s_ar_addr  = ar_addr_arr[rgrant_q];
    assign s_r_ready  = r_fwd && m_r_ready[rgrant_q];
    assign m_r_data   = s_r_data;
    assign m_r_resp   = s_r_resp;

    // Write path: arbitrate on AW, collect AW and W in any order, then B.
    always_comb begin
        wstate_d  = wstate_q;
        wgrant_d  = wgrant_q;
        wptr_d    = wptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (wstate_q)
            W_IDLE: begin
                if (|m_aw_valid) begin
                    wgrant_d  = rr_pick(m_aw_valid, wptr_q);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wstate_d  = W_XFER;
                end
            end
            W_XFER: begin
                if (s_aw_valid && s_aw_ready) aw_done_d = 1'b1;
                if (s_w_valid && s_w_ready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)    wstate_d  = W_RESP;
            end
            W_RESP: begin
                if (s_b_valid && s_b_ready) begin
                    wptr_d   = next_ptr(wgrant_q);
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read path: arbitrate on AR, forward AR, then R.
    always_comb begin
        rstate_d = rstate_q;
        rgrant_d = rgrant_q;
        rptr_d   = rptr_q;
        case (rstate_q)
            R_IDLE: begin
                if (|m_ar_valid) begin
                    rgrant_d = rr_pick(m_ar_valid, rptr_q);
                    rstate_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (s_ar_valid && s_ar_ready) rstate_d = R_DATA;
            end
            R_DATA: begin
                if (s_r_valid && s_r_ready) begin
                    rptr_d   = next_ptr(rgrant_q);
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // State registers for both paths; reset clears grants and pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wstate_q  <= W_IDLE;
            wgrant_q  <= '0;
            wptr_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rstate_q  <= R_IDLE;
            rgrant_q  <= '0;
            rptr_q    <= '0;
        end else begin
            wstate_q  <= wstate_d;
            wgrant_q  <= wgrant_d;
            wptr_q    <= wptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rstate_q  <= rstate_d;
            rgrant_q  <= rgrant_d;
            rptr_q    <= rptr_d;
        end
    end

endmodule

// File: doc/axi4lite_rr_arbiter.md
Name: axi4lite_rr_arbiter

Overview:
Round-robin arbiter sharing one AXI4-Lite slave port between NUM_M AXI4-Lite masters (e.g. the PicoRV32 core data port plus a debug/DMA master). Read and write paths are arbitrated independently, with one outstanding transaction per path. The block sits between the masters and the interconnect/memory slave and forwards the granted master's channels unmodified.

Parameters:
NUM_M, 2, number of masters (2..8)
AW, 32, address width
DW, 32, data width (strobe width DW/8)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
m_aw_valid  in  NUM_M  per-master AW valid
m_aw_ready  out  NUM_M  per-master AW ready
m_aw_addr  in  NUM_M*AW  per-master AW address, master i at [i*AW +: AW]
m_w_valid  in  NUM_M  per-master W valid
m_w_ready  out  NUM_M  per-master W ready
m_w_data  in  NUM_M*DW  per-master write data
m_w_strb  in  NUM_M*DW/8  per-master write strobes
m_b_valid  out  NUM_M  per-master B valid
m_b_ready  in  NUM_M  per-master B ready
m_b_resp  out  2  B response, broadcast; qualified by m_b_valid
m_ar_valid  in  NUM_M  per-master AR valid
m_ar_ready  out  NUM_M  per-master AR ready
m_ar_addr  in  NUM_M*AW  per-master AR address
m_r_valid  out  NUM_M  per-master R valid
m_r_ready  in  NUM_M  per-master R ready
m_r_data  out  DW  R data, broadcast; qualified by m_r_valid
m_r_resp  out  2  R response, broadcast
s_aw_valid/s_aw_ready/s_aw_addr  out/in/out  1/1/AW  slave AW channel
s_w_valid/s_w_ready/s_w_data/s_w_strb  out/in/out/out  1/1/DW/DW/8  slave W channel
s_b_valid/s_b_ready/s_b_resp  in/out/in  1/1/2  slave B channel
s_ar_valid/s_ar_ready/s_ar_addr  out/in/out  1/1/AW  slave AR channel
s_r_valid/s_r_ready/s_r_data/s_r_resp  in/out/in/in  1/1/DW/2  slave R channel

Behaviour:
- Reset (async, rst_ni=0): both FSMs go to IDLE; wgrant=rgrant=0; both RR pointers=0 (master 0 highest priority). All valid/ready outputs are 0. Data/addr outputs are don't-care but are driven from the mux.
- Write FSM states: W_IDLE, W_XFER, W_RESP.
  - W_IDLE: request vector = m_aw_valid. m_w_valid alone never requests. If any request, pick the first set bit searching from wptr upward with wrap, register wgrant, clear aw_done/w_done, go to W_XFER. This is 1 cycle of arbitration latency; nothing is forwarded in W_IDLE.
  - W_XFER: s_aw_valid = m_aw_valid[wgrant] & ~aw_done. s_w_valid = m_w_valid[wgrant] & ~w_done. Readies are routed back to wgrant only. Set aw_done/w_done on the respective handshake; AW and W may complete in either order or the same cycle. When both are done (including same-cycle completion), go to W_RESP.
  - W_RESP: s_b_ready = m_b_ready[wgrant]; m_b_valid[wgrant] = s_b_valid. On the B handshake, wptr = (wgrant+1) mod NUM_M and go to W_IDLE.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: arbitration identical to the write FSM, using m_ar_valid, rptr and rgrant.
  - R_ADDR: forward AR of rgrant; on handshake go to R_DATA.
  - R_DATA: forward R to rgrant. On handshake, rptr = rgrant+1 mod NUM_M and go to R_IDLE.
- The read and write FSMs are fully independent. They may serve the same or different masters concurrently.
- Non-granted masters always see ready=0 and response valid=0.
- Backpressure is passed through combinationally; there is no buffering in the data path.
- A master dropping valid before its handshake is an AXI violation. Behaviour is undefined: the FSM stays in W_XFER/R_ADDR and the bench does not exercise this.
- Back-to-back: minimum cycle for a write is 1 arb + 1 AW/W + 1 B = 3 clocks, and the next arbitration starts the cycle after B. A read is 3 clocks likewise.
- Reset mid-transaction: state is cleared immediately. Any pending slave response is dropped and the slave must also be reset.
- A grant never changes while a transaction is in flight, even if a higher-priority master raises valid.

Test Plan:
- Single write, master 0, addr 0x1000, data 0xDEADBEEF, strb 0xF, slave always ready -> s_aw/s_w seen in cycle 2, m_b_valid[0]=1 in cycle 3, m_b_valid[1] stays 0.
- Masters 0 and 1 both assert AR continuously for 4 reads -> grants alternate 0,1,0,1 and each master receives its own r_data (0xA0+n, 0xB0+n).
- Master 1 presents W two cycles before AW, with the slave's s_aw_ready delayed 3 cycles -> W is not forwarded until AW arrives and is granted; exactly one write to the slave, B to master 1.
- Concurrent: master 0 writes 0x2000 while master 1 reads 0x3000 -> both complete in the same 3-cycle window with no cross-routing of b/r valid.
- Slave holds s_b_valid for 5 cycles with m_b_ready[0]=0, then 1 -> grant held, master 1's AW is not accepted until the cycle after the B handshake.
- rst_ni pulled low during R_DATA -> next cycle all m_*_ready/valid are 0 and rptr=0; after release, master 0 wins a tie with master 1.
